// File: rtl/alu_pkg.sv
// Shared constants for the accumulator ALU: function codes and FSM state encoding.
package alu_pkg;

    localparam logic [2:0] FN_ADD  = 3'b000;
    localparam logic [2:0] FN_SUB  = 3'b001;
    localparam logic [2:0] FN_SEXT = 3'b010;
    localparam logic [2:0] FN_OR   = 3'b011;
    localparam logic [2:0] FN_AND  = 3'b100;
    localparam logic [2:0] FN_SHL  = 3'b101;
    localparam logic [2:0] FN_MUL  = 3'b110;
    localparam logic [2:0] FN_HOLD = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_acc_reg_seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle for WIDTH cycles.
// Only built when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 Clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 step_done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [RW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [RW-1:0]    prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             active_q, active_d;
    logic [RW-1:0]    step_sum;

    // product is the partial product including this cycle's step, so the
    // final value is visible while the last step is being taken
    assign step_sum  = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign product   = step_sum;
    assign step_done = active_q && (cnt_q == LAST_STEP);

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            prod_d   = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule
`endif

// File: rtl/alu_acc_reg.sv
// Accumulator ALU with start/busy/done handshake. Define ALU_MUL_EN to build the
// multi-cycle multiplier; otherwise code 110 completes in one cycle with result 0.
module alu_acc_reg
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 Clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     Data,
    input  logic [2:0]           Function,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   ALUout,
    output logic                 busy,
    output logic                 done
);

    localparam int RW = 2 * WIDTH;

    logic [RW-1:0]    alu_q, alu_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] op_b;
    logic [RW-1:0]    a_ext, b_ext;
    logic [RW-1:0]    alu_result;

    assign op_b   = alu_q[WIDTH-1:0];
    assign a_ext  = {{WIDTH{1'b0}}, Data};
    assign b_ext  = {{WIDTH{1'b0}}, op_b};
    assign ALUout = alu_q;
    assign done   = done_q;

    // A shift amount at or beyond RW naturally yields zero
    always_comb begin
        alu_result = alu_q;
        unique case (Function)
            FN_ADD:  alu_result = a_ext + b_ext;
            FN_SUB:  alu_result = a_ext - b_ext;
            FN_SEXT: alu_result = {{WIDTH{op_b[WIDTH-1]}}, op_b};
            FN_OR:   alu_result = {{(RW-1){1'b0}}, |{Data, op_b}};
            FN_AND:  alu_result = {{(RW-1){1'b0}}, &{Data, op_b}};
            FN_SHL:  alu_result = b_ext << Data;
            FN_MUL:  alu_result = '0;
            FN_HOLD: alu_result = alu_q;
            default: alu_result = alu_q;
        endcase
    end

`ifdef ALU_MUL_EN
    state_t        state_q, state_d;
    logic          mul_load;
    logic          mul_step_done;
    logic [RW-1:0] mul_product;

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .Clock     (Clock),
        .reset     (reset),
        .load      (mul_load),
        .a         (Data),
        .b         (op_b),
        .step_done (mul_step_done),
        .product   (mul_product)
    );

    assign busy = (state_q == ST_MUL);

    always_comb begin
        state_d  = state_q;
        alu_d    = alu_q;
        done_d   = 1'b0;
        mul_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (Function == FN_MUL) begin
                        mul_load = 1'b1;
                        state_d  = ST_MUL;
                    end else begin
                        alu_d  = alu_result;
                        done_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_step_done) begin
                    alu_d   = mul_product;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    assign busy = 1'b0;

    always_comb begin
        alu_d  = alu_q;
        done_d = 1'b0;
        if (start) begin
            alu_d  = alu_result;
            done_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge Clock) begin
        if (!reset) begin
            alu_q  <= '0;
            done_q <= 1'b0;
        end else begin
            alu_q  <= alu_d;
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_acc_reg.sv
// Self-checking bench for alu_acc_reg (WIDTH=4): vector table, hand-written corner
// sequences, and randomized traffic against a behavioural model.
module tb_alu_acc_reg;

    localparam int W     = 4;
    localparam int RW    = 2 * W;
    localparam int WMASK = (1 << W) - 1;
    localparam int RMASK = (1 << RW) - 1;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          Clock;
    logic          reset;
    logic [W-1:0]  Data;
    logic [2:0]    Function;
    logic          start;
    logic [RW-1:0] ALUout;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    alu_acc_reg #(.WIDTH(W)) dut (
        .Clock    (Clock),
        .reset    (reset),
        .Data     (Data),
        .Function (Function),
        .start    (start),
        .ALUout   (ALUout),
        .busy     (busy),
        .done     (done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [2:0] fn;
        int         data;
        int         exp_alu;
    } vec_t;

    // Reference result of a single-cycle operation, from the arithmetic definitions
    function automatic int ref_op(input int fn, input int a, input int acc);
        int b;
        b = acc & WMASK;
        case (fn)
            0: return (a + b) & RMASK;
            1: return (a - b) & RMASK;
            2: return (b >= (1 << (W - 1))) ? (b + (RMASK - WMASK)) : b;
            3: return ((a != 0) || (b != 0)) ? 1 : 0;
            4: return ((a == WMASK) && (b == WMASK)) ? 1 : 0;
            5: return (a >= RW) ? 0 : ((b << a) & RMASK);
            6: return MUL_EN ? ((a * b) & RMASK) : 0;
            default: return acc;
        endcase
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] fn, input int data, input logic st);
        Function = fn;
        Data     = W'(data);
        start    = st;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    vec_t vecs[$];

    // Model state for randomized traffic
    int m_acc, m_left, m_prod, m_done;

    initial begin
        reset = 1'b1;
        apply_stimulus(3'b000, 0, 1'b0);
        tick();

        reset = 1'b0;
        tick();
        check_output("reset_alu", int'(ALUout), 0);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_done", int'(done), 0);
        reset = 1'b1;

        vecs.push_back('{3'b000, 4'hF, 8'h0F});
        vecs.push_back('{3'b000, 4'h1, 8'h10});
        vecs.push_back('{3'b111, 4'h7, 8'h10});
        vecs.push_back('{3'b010, 4'h3, 8'h00});
        vecs.push_back('{3'b000, 4'h5, 8'h05});
        vecs.push_back('{3'b001, 4'h3, 8'hFE});
        vecs.push_back('{3'b010, 4'h0, 8'hFE});
        vecs.push_back('{3'b000, 4'h0, 8'h0E});
        vecs.push_back('{3'b100, 4'hF, 8'h00});
        vecs.push_back('{3'b011, 4'h0, 8'h00});
        vecs.push_back('{3'b000, 4'h9, 8'h09});
        vecs.push_back('{3'b101, 4'h4, 8'h90});
        vecs.push_back('{3'b000, 4'h9, 8'h09});
        vecs.push_back('{3'b101, 4'hF, 8'h00});
        vecs.push_back('{3'b000, 4'hF, 8'h0F});
        vecs.push_back('{3'b100, 4'hF, 8'h01});
        vecs.push_back('{3'b011, 4'h0, 8'h01});
        vecs.push_back('{3'b001, 4'h0, 8'hFF});

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].fn, vecs[i].data, 1'b1);
            tick();
            check_output($sformatf("vec%0d_alu", i), int'(ALUout), vecs[i].exp_alu);
            check_output($sformatf("vec%0d_done", i), int'(done), 1);
            check_output($sformatf("vec%0d_busy", i), int'(busy), 0);
        end
        apply_stimulus(3'b000, 0, 1'b0);
        tick();
        check_output("idle_done_low", int'(done), 0);
        check_output("idle_alu_kept", int'(ALUout), 8'hFF);

        // Multiply latency and ignored mid-multiply start
        reset = 1'b0;
        tick();
        reset = 1'b1;
        apply_stimulus(3'b000, 4'hF, 1'b1);
        tick();
        apply_stimulus(3'b110, 4'hF, 1'b1);
        tick();
        apply_stimulus(3'b000, 0, 1'b0);
        if (MUL_EN) begin
            for (int c = 0; c < W; c++) begin
                check_output($sformatf("mul_busy%0d", c), int'(busy), 1);
                check_output($sformatf("mul_nodone%0d", c), int'(done), 0);
                check_output($sformatf("mul_hold%0d", c), int'(ALUout), 8'h0F);
                apply_stimulus(3'b000, 4'h1, (c == 1) ? 1'b1 : 1'b0);
                tick();
            end
            apply_stimulus(3'b000, 0, 1'b0);
        end
        check_output("mul_result", int'(ALUout), MUL_EN ? 8'hE1 : 8'h00);
        check_output("mul_done", int'(done), 1);
        check_output("mul_busy_end", int'(busy), 0);
        tick();
        check_output("mul_done_drop", int'(done), 0);

        // Reset in the second multiply cycle
        if (MUL_EN) begin
            apply_stimulus(3'b000, 4'h3, 1'b1);
            tick();
            apply_stimulus(3'b110, 4'h5, 1'b1);
            tick();
            apply_stimulus(3'b000, 0, 1'b0);
            tick();
            reset = 1'b0;
            tick();
            reset = 1'b1;
            check_output("rstmul_alu", int'(ALUout), 0);
            check_output("rstmul_busy", int'(busy), 0);
            check_output("rstmul_done", int'(done), 0);
            for (int c = 0; c < W + 1; c++) begin
                tick();
                check_output($sformatf("rstmul_quiet%0d", c), int'(done) + int'(busy), 0);
            end
            apply_stimulus(3'b000, 4'h2, 1'b1);
            tick();
            apply_stimulus(3'b000, 0, 1'b0);
            check_output("rstmul_add", int'(ALUout), 8'h02);
        end

        // Randomized traffic against the behavioural model
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m_acc  = 0;
        m_left = 0;
        m_prod = 0;
        m_done = 0;
        for (int n = 0; n < 400; n++) begin
            int fn, a, st, rs;
            fn = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, WMASK));
            st = ($urandom_range(0, 3) != 0) ? 1 : 0;
            rs = ($urandom_range(0, 49) == 0) ? 0 : 1;
            apply_stimulus(fn[2:0], a, st[0]);
            reset = rs[0];
            if (rs == 0) begin
                m_acc  = 0;
                m_left = 0;
                m_done = 0;
            end else if (m_left > 0) begin
                m_left--;
                m_done = 0;
                if (m_left == 0) begin
                    m_acc  = m_prod;
                    m_done = 1;
                end
            end else if (st == 1) begin
                if (fn == 6 && MUL_EN) begin
                    m_prod = (a * (m_acc & WMASK)) & RMASK;
                    m_left = W;
                    m_done = 0;
                end else begin
                    m_acc  = ref_op(fn, a, m_acc);
                    m_done = 1;
                end
            end else begin
                m_done = 0;
            end
            tick();
            check_output($sformatf("rnd%0d_alu", n), int'(ALUout), m_acc);
            check_output($sformatf("rnd%0d_busy", n), int'(busy), (m_left > 0) ? 1 : 0);
            check_output($sformatf("rnd%0d_done", n), int'(done), m_done);
        end
        reset = 1'b1;
        apply_stimulus(3'b000, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_acc_reg.md
# alu_acc_reg

Parametrised accumulator ALU: a `WIDTH`-bit operand combines with the low `WIDTH` bits of a `2*WIDTH`-bit result register, and the result is written back to that register. It is the next-generation lab datapath block, sitting between switch/Data inputs and the hex_decoder display path. Relative to the fixed 4-bit predecessor it adds:
- width parametrisation;
- a start/busy/done handshake;
- a subtract operation;
- a multi-cycle shift-add multiplier.

## Interface
- `WIDTH`, default 4: operand width; result/accumulator width is `2*WIDTH`.
- `Clock` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: reset, synchronous, active-low; clock Clock.
- `Data` input, `WIDTH` bits: operand A.
- `Function` input, 3 bits: operation select, sampled with `start`.
- `start` input, 1 bit: request one operation; ignored while `busy`.
- `ALUout` output, `2*WIDTH` bits: result register. Operand B is always `ALUout[WIDTH-1:0]`.
- `busy` output, 1 bit: high while a multiply is in progress.
- `done` output, 1 bit: one-cycle pulse when `ALUout` has just been updated.

## Operation
- A = `Data`, captured at the accepting edge. B = `ALUout[WIDTH-1:0]` at the accepting edge.
- All arithmetic is unsigned unless stated. Results are zero-extended to `2*WIDTH`.
- `000` ADD: A+B; the carry lands in bit `WIDTH`.
- `001` SUB: A−B, two's complement, sign-extended to `2*WIDTH`.
- `010` SEXT: B sign-extended from bit `WIDTH-1`.
- `011` OR: result is 1 if `|{A,B}`, else 0.
- `100` AND: result is 1 if `&{A,B}`, else 0.
- `101` SHL: B<<A, computed in `2*WIDTH` bits; bits shifted out are lost. A ≥ `2*WIDTH` gives 0.
- `110` MUL: A*B, full `2*WIDTH`-bit product, computed by iterative shift-add.
- `111` HOLD: `ALUout` is unchanged, but `done` still pulses.
- FSM states:
  - IDLE: `start`=1 with a non-MUL code → write the result, stay in IDLE.
  - IDLE: `start`=1 with MUL → latch A and B, clear the partial product, go to MUL.
  - MUL: one multiplier bit per cycle for `WIDTH` cycles. After the last step, write the product to `ALUout` and return to IDLE.
- `start` in MUL is ignored and not queued.
- Reset (`reset`=0 at any edge, including mid-multiply) takes priority over everything: `ALUout`=0, `busy`=0, `done`=0, FSM=IDLE, partial product cleared.

## Timing
- Single-cycle operations: `start` sampled at edge k → `ALUout` holds the new value after edge k, and `done`=1 for the cycle following edge k.
- MUL:
  - `start` at edge k → `busy`=1 from edge k through edge k+`WIDTH`.
  - `ALUout` is updated at edge k+`WIDTH`, with `done`=1 for the following cycle.
  - `ALUout` keeps its old value throughout the multiply.
- Back-to-back: `start` held high in IDLE accepts an operation every cycle. The earliest acceptance after a MUL is edge k+`WIDTH`+1.
- `done` and `busy` are never high in the same cycle.

## Configuration
- `ALU_MUL_EN` defined: MUL behaves as above.
- `ALU_MUL_EN` undefined: the multiplier and MUL state are compiled out. Code `110` completes in one cycle with `ALUout`=0 and a `done` pulse, and `busy` is tied to 0.

## Structure
- Package `alu_pkg` holds:
  - the function-code constants `FN_ADD` … `FN_HOLD`;
  - the FSM state encoding (`ST_IDLE`, `ST_MUL`).
- Sub-module `seq_multiplier` holds the shift-add datapath and its step counter. Its interface: `load`, A, B, `step_done`, `product`.
- Top level contains the combinational ALU, the FSM and the result register.

## Test plan
- Reset: drive `reset`=0 for one edge → `ALUout`=0x00, `busy`=0, `done`=0.
- ADD carry (WIDTH=4): set B=0xF (seed with ADD 0xF from 0), then ADD `Data`=0x1 → `ALUout`=0x10 next cycle, with a one-cycle `done` pulse.
- SUB/SEXT:
  - From `ALUout`=0x05, SUB `Data`=0x3 → 0xFE.
  - Then SEXT → 0xFE. B=0xE sign-extends to 0xFE.
- MUL latency: from `ALUout`=0x0F, MUL `Data`=0xF → `busy` high for 4 cycles, then `ALUout`=0xE1 and `done` for 1 cycle. A `start` pulse mid-multiply has no effect.
- SHL boundaries:
  - B=0x9, `Data`=0x4 → 0x90.
  - B=0x9, `Data`=0xF → 0x00.
- Reset mid-MUL: assert `reset`=0 on the second multiply cycle → `ALUout`=0, `busy`=0, and no `done` pulse. A subsequent ADD `Data`=0x2 → 0x02.
